tff_counter_ctrl: RTL and testbench

//  Controller that sequences a WIDTH-bit bank of T flip-flops as a programmable synchronous counter.

---
 rtl/tff_counter_ctrl.sv | 140 ++++++++++++++
 tb/tb_tff_counter_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/tff_counter_ctrl.sv
// Sequencer for a WIDTH-bit T flip-flop bank used as a programmable synchronous counter.
// Optional down-count support is enabled by defining TFF_CTRL_DOWN_EN (adds the dir port).
module tff_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  input  logic             reload,
`ifdef TFF_CTRL_DOWN_EN
  input  logic             dir,
`endif
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             tc_pulse
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       state_nx_s;
  logic [WIDTH-1:0] limit_r;
  logic [WIDTH-1:0] limit_nx_s;
  logic             reload_r;
  logic             reload_nx_s;
  logic             dir_r;
  logic             dir_nx_s;
  logic             dir_in_s;
  logic [WIDTH-1:0] count_nx_s;
  logic             tc_nx_s;
  logic [WIDTH-1:0] t_s;
  logic [WIDTH-1:0] start_load_s;
  logic [WIDTH-1:0] wrap_load_s;
  logic             terminal_s;

`ifdef TFF_CTRL_DOWN_EN
  assign dir_in_s = dir;
`else
  assign dir_in_s = 1'b0;
`endif

  // Down-counting starts from the freshly sampled limit and wraps back to the latched one.
  assign start_load_s = dir_in_s ? limit : {WIDTH{1'b0}};
  assign wrap_load_s  = dir_r ? limit_r : {WIDTH{1'b0}};
  assign terminal_s   = dir_r ? (count == {WIDTH{1'b0}}) : (count == limit_r);

  // Toggle enables: t[0]=1, t[i] = AND of lower bits (inverted lower bits when counting down).
  always_comb begin
    logic chain_s;
    chain_s = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      t_s[i]  = chain_s;
      chain_s = chain_s & (dir_r ? ~count[i] : count[i]);
    end
  end

  // Next-state, next-count and terminal-pulse decode; stop beats pause beats start.
  always_comb begin
    state_nx_s  = state_r;
    count_nx_s  = count;
    tc_nx_s     = 1'b0;
    limit_nx_s  = limit_r;
    reload_nx_s = reload_r;
    dir_nx_s    = dir_r;
    if (stop) begin
      state_nx_s = IDLE;
      count_nx_s = {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (!pause && start) begin
            state_nx_s  = RUN;
            count_nx_s  = start_load_s;
            limit_nx_s  = limit;
            reload_nx_s = reload;
            dir_nx_s    = dir_in_s;
          end else begin
            state_nx_s = state_r;
          end
        end
        RUN: begin
          if (pause) begin
            state_nx_s = PAUSE;
          end else if (terminal_s) begin
            tc_nx_s = 1'b1;
            if (reload_r) begin
              count_nx_s = wrap_load_s;
            end else begin
              state_nx_s = DONE;
            end
          end else begin
            count_nx_s = count ^ t_s;
          end
        end
        PAUSE: begin
          if (pause) begin
            state_nx_s = PAUSE;
          end else begin
            state_nx_s = RUN;
          end
        end
        default: begin
          state_nx_s = IDLE;
          count_nx_s = {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // State, count bank and status outputs, all registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      count    <= {WIDTH{1'b0}};
      tc_pulse <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      limit_r  <= {WIDTH{1'b0}};
      reload_r <= 1'b0;
      dir_r    <= 1'b0;
    end else begin
      state_r  <= state_nx_s;
      count    <= count_nx_s;
      tc_pulse <= tc_nx_s;
      busy     <= (state_nx_s == RUN) || (state_nx_s == PAUSE);
      done     <= (state_nx_s == DONE);
      limit_r  <= limit_nx_s;
      reload_r <= reload_nx_s;
      dir_r    <= dir_nx_s;
    end
  end

endmodule

// File: tb/tb_tff_counter_ctrl.sv
// Directed self-checking bench for tff_counter_ctrl (WIDTH=4).
// Down-count checks are compiled in when TFF_CTRL_DOWN_EN is defined.
module tb_tff_counter_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       pause;
  logic       stop;
  logic       reload;
  logic [3:0] limit;
  logic [3:0] count;
  logic       busy;
  logic       done;
  logic       tc_pulse;
`ifdef TFF_CTRL_DOWN_EN
  logic       dir;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  tff_counter_ctrl #(.WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pause    (pause),
    .stop     (stop),
    .reload   (reload),
`ifdef TFF_CTRL_DOWN_EN
    .dir      (dir),
`endif
    .limit    (limit),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .tc_pulse (tc_pulse)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int exp_cnt [6] = '{1, 2, 0, 1, 2, 0};
    int exp_tc  [6] = '{0, 0, 1, 0, 0, 1};
    rst = 1'b1; start = 1'b0; pause = 1'b0; stop = 1'b0; reload = 1'b0; limit = 4'd0;
`ifdef TFF_CTRL_DOWN_EN
    dir = 1'b0;
`endif
    tick(); tick();
    chk("rst_count", count, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tc", tc_pulse, 0);
    rst = 1'b0;
    tick();
    chk("idle_count", count, 0);

    // One-shot to limit 3
    limit = 4'd3; reload = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("os_start_count", count, 0);
    chk("os_start_busy", busy, 1);
    tick(); chk("os_c1", count, 1);
    tick(); chk("os_c2", count, 2);
    tick(); chk("os_c3", count, 3); chk("os_c3_tc", tc_pulse, 0);
    tick();
    chk("os_tc", tc_pulse, 1); chk("os_done", done, 1);
    chk("os_busy", busy, 0);   chk("os_hold", count, 3);
    tick();
    chk("os_tc_drop", tc_pulse, 0); chk("os_done_hold", done, 1); chk("os_hold2", count, 3);

    // Auto-reload limit 2, restarted from DONE; later limit changes are ignored
    limit = 4'd2; reload = 1'b1; start = 1'b1;
    tick();
    start = 1'b0; limit = 4'd9;
    chk("rl_start_count", count, 0); chk("rl_done_clr", done, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rl_count", count, exp_cnt[i]);
      chk("rl_tc", tc_pulse, exp_tc[i]);
      chk("rl_busy", busy, 1);
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop_count", count, 0); chk("stop_busy", busy, 0);

    // Pause at count 6
    limit = 4'd15; reload = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    chk("pz_pre", count, 6);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pz_hold", count, 6);
      chk("pz_busy", busy, 1);
      chk("pz_tc", tc_pulse, 0);
    end
    pause = 1'b0;
    tick(); chk("pz_resume_edge", count, 6);
    tick(); chk("pz_resume", count, 7); chk("pz_resume_tc", tc_pulse, 0);

    // stop+pause+start together at count 9
    tick(); tick();
    chk("spx_pre", count, 9);
    stop = 1'b1; pause = 1'b1; start = 1'b1;
    tick();
    stop = 1'b0; pause = 1'b0; start = 1'b0;
    chk("spx_count", count, 0); chk("spx_busy", busy, 0); chk("spx_done", done, 0);

    // limit=0 one-shot
    limit = 4'd0; reload = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("l0os_busy", busy, 1); chk("l0os_tc0", tc_pulse, 0);
    tick();
    chk("l0os_tc", tc_pulse, 1); chk("l0os_done", done, 1); chk("l0os_count", count, 0);
    tick();
    chk("l0os_tc_drop", tc_pulse, 0);

    // limit=0 auto-reload: pulse every RUN cycle
    reload = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); chk("l0rl_tc1", tc_pulse, 1);
    tick(); chk("l0rl_tc2", tc_pulse, 1); chk("l0rl_busy", busy, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("l0rl_stop_tc", tc_pulse, 0);

    // Async reset mid-run at count 5
    limit = 4'd15; reload = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    chk("ar_pre", count, 5);
    #3 rst = 1'b1;
    #1;
    chk("ar_count", count, 0); chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);   chk("ar_tc", tc_pulse, 0);
    tick();
    rst = 1'b0;

    // Full-range wrap at 15
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    chk("wrap_pre", count, 15); chk("wrap_pre_tc", tc_pulse, 0);
    tick();
    chk("wrap_count", count, 0); chk("wrap_tc", tc_pulse, 1); chk("wrap_busy", busy, 1);
    stop = 1'b1; tick(); stop = 1'b0;

`ifdef TFF_CTRL_DOWN_EN
    // Down count from 4 with reload
    dir = 1'b1; limit = 4'd4; reload = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("dn_load", count, 4);
    tick(); chk("dn_3", count, 3);
    tick(); chk("dn_2", count, 2);
    tick(); chk("dn_1", count, 1);
    tick(); chk("dn_0", count, 0); chk("dn_0_tc", tc_pulse, 0);
    tick(); chk("dn_reload", count, 4); chk("dn_tc", tc_pulse, 1);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("dn_stop", count, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
